thrust_sequencer: RTL and testbench

Player-control sequencer that produces the 8-bit THRUST value fed to LLANDER_TOP. It selects between the analog stick and a D-pad-driven accumulator, and rate-limits D-pad changes with a tick prescaler. It also gives a bumpless handover when the operator switches thrust source at runtime. Also owns the difficulty-overlay hold timer and difficulty encoding, replacing ad-hoc counters in the emu top level.

---
 rtl/llander_ctrl_pkg.sv | 25 ++
 rtl/tick_gen.sv | 26 ++
 rtl/thrust_sequencer.sv | 125 ++++++++++++
 tb/tb_thrust_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llander_ctrl_pkg.sv
// Shared types and constants for the lunar-lander player-control logic.
package llander_ctrl_pkg;

    typedef enum logic [1:0] {
        ANALOG = 2'd0,
        DPAD   = 2'd1,
        SLEW   = 2'd2
    } thrust_state_t;

    localparam int THRUST_MAX_DEFAULT = 254;

    localparam logic [1:0] DIFF_NONE  = 2'd0;
    localparam logic [1:0] DIFF_LAMP3 = 2'd1;
    localparam logic [1:0] DIFF_LAMP4 = 2'd2;
    localparam logic [1:0] DIFF_LAMP5 = 2'd3;

    // lamp is {lamp5, lamp4, lamp3}; the highest lit lamp decides the level.
    function automatic logic [1:0] encode_difficulty(input logic [2:0] lamp);
        if (lamp[2])      return DIFF_LAMP5;
        else if (lamp[1]) return DIFF_LAMP4;
        else if (lamp[0]) return DIFF_LAMP3;
        else              return DIFF_NONE;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler emitting a one-cycle strobe every DIV clocks.
module tick_gen #(
    parameter int DIV = 196850
) (
    input  logic clk_50,
    input  logic RESET_L,
    output logic tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L)
            cnt_q <= '0;
        else if (cnt_q == LAST)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/thrust_sequencer.sv
// Thrust source selection (stick / D-pad ramp) with bumpless handover,
// plus the difficulty overlay hold timer and lamp-based difficulty encoder.
module thrust_sequencer
    import llander_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 196850,
    parameter int THRUST_MAX = THRUST_MAX_DEFAULT,
    parameter int SLEW_STEP  = 4,
    parameter int OSD_HOLD   = 500000000
) (
    input  logic       clk_50,
    input  logic       RESET_L,
    input  logic       dpad_mode,
    input  logic [7:0] analog_y,
    input  logic       joy_up,
    input  logic       joy_down,
    input  logic       select_l,
    input  logic [2:0] lamp,
    output logic [7:0] thrust,
    output logic       tick,
    output logic       osd_en,
    output logic [1:0] difficulty
);

    localparam logic [7:0]       T_MAX    = 8'(THRUST_MAX);
    localparam logic [7:0]       STEP     = 8'(SLEW_STEP);
    localparam int               OSD_W    = $clog2(OSD_HOLD + 1);
    localparam logic [OSD_W-1:0] OSD_LOAD = OSD_W'(OSD_HOLD);

    function automatic logic [7:0] clamp_target(input logic signed [8:0] v);
        if (v > $signed({1'b0, T_MAX})) return T_MAX;
        else                            return v[7:0];
    endfunction

    function automatic logic [7:0] slew_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (tgt > cur)      return ((tgt - cur) > STEP) ? cur + STEP : tgt;
        else if (tgt < cur) return ((cur - tgt) > STEP) ? cur - STEP : tgt;
        else                return cur;
    endfunction

    thrust_state_t     state_q, state_d;
    logic [7:0]        acc_q, acc_d;
    logic              dpad_q;
    logic              dpad_rise, dpad_fall;
    logic signed [8:0] a_raw_s;
    logic [7:0]        a_tgt;
    logic [7:0]        slew_nxt;
    logic [OSD_W-1:0]  osd_cnt_q;

    tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk_50  (clk_50),
        .RESET_L (RESET_L),
        .tick    (tick)
    );

    // Stick Y is inverted: full forward (-128) is full thrust.
    assign a_raw_s   = 9'sd127 - $signed({analog_y[7], analog_y});
    assign a_tgt     = clamp_target(a_raw_s);
    assign slew_nxt  = slew_toward(acc_q, a_tgt);
    assign dpad_rise = dpad_mode & ~dpad_q;
    assign dpad_fall = ~dpad_mode & dpad_q;

    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q <= ANALOG;
            acc_q   <= '0;
            dpad_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dpad_q  <= dpad_mode;
        end
    end

    // acc doubles as the thrust register, so a mode switch keeps the value it had.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        case (state_q)
            ANALOG: begin
                if (dpad_rise) state_d = DPAD;
                else           acc_d   = a_tgt;
            end
            DPAD: begin
                if (dpad_fall) begin
                    state_d = SLEW;
                end else if (tick) begin
                    if (joy_up) begin
                        if (acc_q < T_MAX) acc_d = acc_q + 8'd1;
                    end else if (joy_down && acc_q != 8'd0) begin
                        acc_d = acc_q - 8'd1;
                    end
                end
            end
            SLEW: begin
                if (dpad_rise) begin
                    state_d = DPAD;
                end else if (tick) begin
                    acc_d = slew_nxt;
                    if (slew_nxt == a_tgt) state_d = ANALOG;
                end
            end
            default: state_d = ANALOG;
        endcase
    end

    assign thrust = acc_q;

    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L)
            osd_cnt_q <= '0;
        else if (!select_l)
            osd_cnt_q <= OSD_LOAD;
        else if (osd_cnt_q != '0)
            osd_cnt_q <= osd_cnt_q - 1'b1;
    end

    assign osd_en = (osd_cnt_q != '0);

    always_ff @(posedge clk_50 or negedge RESET_L) begin
        if (!RESET_L) difficulty <= DIFF_NONE;
        else          difficulty <= encode_difficulty(lamp);
    end

endmodule

// File: tb/tb_thrust_sequencer.sv
// Directed bench for thrust_sequencer with a short prescaler and overlay hold.
module tb_thrust_sequencer;

    localparam int TICK_DIV   = 4;
    localparam int THRUST_MAX = 254;
    localparam int SLEW_STEP  = 4;
    localparam int OSD_HOLD   = 20;

    typedef struct {
        logic [7:0] y;
        logic [2:0] lamp;
        int         thr;
        int         diff;
    } vec_t;

    logic       clk_50 = 1'b0;
    logic       RESET_L = 1'b0;
    logic       dpad_mode = 1'b0;
    logic [7:0] analog_y = 8'h80;
    logic       joy_up = 1'b0;
    logic       joy_down = 1'b0;
    logic       select_l = 1'b1;
    logic [2:0] lamp = 3'b111;
    logic [7:0] thrust;
    logic       tick;
    logic       osd_en;
    logic [1:0] difficulty;

    int n_checks = 0;
    int n_fail = 0;
    int exp_cnt = 0;
    bit was_tick = 1'b0;
    int exp_thr = 0;
    int nt = 0;
    vec_t vecs[7];

    thrust_sequencer #(
        .TICK_DIV   (TICK_DIV),
        .THRUST_MAX (THRUST_MAX),
        .SLEW_STEP  (SLEW_STEP),
        .OSD_HOLD   (OSD_HOLD)
    ) dut (
        .clk_50     (clk_50),
        .RESET_L    (RESET_L),
        .dpad_mode  (dpad_mode),
        .analog_y   (analog_y),
        .joy_up     (joy_up),
        .joy_down   (joy_down),
        .select_l   (select_l),
        .lamp       (lamp),
        .thrust     (thrust),
        .tick       (tick),
        .osd_en     (osd_en),
        .difficulty (difficulty)
    );

    always #5 clk_50 = ~clk_50;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock: remember whether this edge carried a tick, then check tick.
    task automatic step();
        was_tick = (exp_cnt == TICK_DIV - 1);
        @(posedge clk_50);
        exp_cnt = (exp_cnt + 1) % TICK_DIV;
        #1;
        check("tick", int'(tick), int'(exp_cnt == TICK_DIV - 1));
    endtask

    function automatic int toward(input int cur, input int tgt);
        if (tgt - cur > SLEW_STEP) return cur + SLEW_STEP;
        if (cur - tgt > SLEW_STEP) return cur - SLEW_STEP;
        return tgt;
    endfunction

    initial begin
        vecs[0] = '{8'h80, 3'b110, 254, 3};
        vecs[1] = '{8'h00, 3'b000, 127, 0};
        vecs[2] = '{8'h7F, 3'b001,   0, 1};
        vecs[3] = '{8'h81, 3'b010, 254, 2};
        vecs[4] = '{8'h01, 3'b011, 126, 2};
        vecs[5] = '{8'hFF, 3'b100, 128, 3};
        vecs[6] = '{8'h9C, 3'b111, 227, 3};

        #12;
        check("rst_thrust", int'(thrust), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_osd", int'(osd_en), 0);
        check("rst_diff", int'(difficulty), 0);

        @(negedge clk_50);
        RESET_L = 1'b1;
        exp_cnt = 0;

        for (int i = 0; i < 7; i++) begin
            analog_y = vecs[i].y;
            lamp     = vecs[i].lamp;
            step();
            check("analog_map", int'(thrust), vecs[i].thr);
            check("difficulty", int'(difficulty), vecs[i].diff);
        end

        // D-pad ramp up from 0 to the clamp and hold there
        analog_y = 8'h7F;
        step();
        check("pre_ramp", int'(thrust), 0);
        dpad_mode = 1'b1;
        joy_up = 1'b1;
        step();
        check("ramp_enter", int'(thrust), 0);
        exp_thr = 0;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (was_tick && exp_thr < THRUST_MAX) exp_thr++;
            check("ramp_up", int'(thrust), exp_thr);
        end
        check("ramp_hold_max", int'(thrust), 254);

        joy_up = 1'b0;
        joy_down = 1'b1;
        for (int i = 0; i < 1000 && exp_thr > 100; i++) begin
            step();
            if (was_tick) exp_thr--;
            check("ramp_down", int'(thrust), exp_thr);
        end
        check("down_reach_100", int'(thrust), 100);

        joy_up = 1'b1;
        nt = 0;
        for (int i = 0; i < 40 && nt < 3; i++) begin
            step();
            if (was_tick) begin
                nt++;
                exp_thr++;
            end
            check("both_held", int'(thrust), exp_thr);
        end
        check("both_103", int'(thrust), 103);
        joy_up = 1'b0;
        joy_down = 1'b0;

        // Slew back to the stick at y=0, then bumpless entry into D-pad
        analog_y = 8'h00;
        dpad_mode = 1'b0;
        step();
        check("slew_enter", int'(thrust), 103);
        for (int i = 0; i < 60; i++) begin
            step();
            if (was_tick) exp_thr = toward(exp_thr, 127);
            check("slew_to_127", int'(thrust), exp_thr);
        end
        check("slew_done", int'(thrust), 127);

        dpad_mode = 1'b1;
        analog_y = 8'h80;
        for (int i = 0; i < 12; i++) begin
            step();
            check("bumpless_hold", int'(thrust), 127);
        end

        joy_up = 1'b1;
        exp_thr = 127;
        for (int i = 0; i < 100 && exp_thr < 140; i++) begin
            step();
            if (was_tick) exp_thr++;
            check("ramp_to_140", int'(thrust), exp_thr);
        end
        joy_up = 1'b0;
        check("at_140", int'(thrust), 140);

        analog_y = 8'h9C;
        dpad_mode = 1'b0;
        step();
        check("slew2_enter", int'(thrust), 140);
        for (int i = 0; i < 200 && exp_thr != 227; i++) begin
            step();
            if (was_tick) exp_thr = toward(exp_thr, 227);
            check("slew_to_227", int'(thrust), exp_thr);
        end
        check("slew2_done", int'(thrust), 227);
        analog_y = 8'h00;
        step();
        check("analog_resume", int'(thrust), 127);

        // Overlay: single pulse, reload at cycle 10, held low
        select_l = 1'b0;
        step();
        select_l = 1'b1;
        check("osd_pulse", int'(osd_en), 1);
        for (int i = 1; i < 20; i++) begin
            step();
            check("osd_hold", int'(osd_en), 1);
        end
        step();
        check("osd_expire", int'(osd_en), 0);

        select_l = 1'b0;
        step();
        select_l = 1'b1;
        for (int i = 1; i < 10; i++) begin
            step();
            check("osd_pre_reload", int'(osd_en), 1);
        end
        select_l = 1'b0;
        step();
        select_l = 1'b1;
        check("osd_reload", int'(osd_en), 1);
        for (int i = 11; i < 30; i++) begin
            step();
            check("osd_extended", int'(osd_en), 1);
        end
        step();
        check("osd_ext_expire", int'(osd_en), 0);

        select_l = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            check("osd_held_low", int'(osd_en), 1);
        end
        select_l = 1'b1;
        for (int i = 1; i < 20; i++) begin
            step();
            check("osd_after_release", int'(osd_en), 1);
        end
        step();
        check("osd_release_expire", int'(osd_en), 0);

        // Asynchronous reset in the middle of a downward slew
        lamp = 3'b100;
        select_l = 1'b0;
        dpad_mode = 1'b1;
        step();
        check("mid_dpad", int'(thrust), 127);
        select_l = 1'b1;
        analog_y = 8'h7F;
        dpad_mode = 1'b0;
        step();
        check("mid_slew_enter", int'(thrust), 127);
        exp_thr = 127;
        for (int i = 0; i < 8; i++) begin
            step();
            if (was_tick) exp_thr = toward(exp_thr, 0);
            check("mid_slew", int'(thrust), exp_thr);
        end
        check("pre_rst_osd", int'(osd_en), 1);
        check("pre_rst_diff", int'(difficulty), 3);
        #2;
        RESET_L = 1'b0;
        dpad_mode = 1'b1;
        #1;
        check("async_rst_thrust", int'(thrust), 0);
        check("async_rst_osd", int'(osd_en), 0);
        check("async_rst_tick", int'(tick), 0);
        check("async_rst_diff", int'(difficulty), 0);

        @(negedge clk_50);
        RESET_L = 1'b1;
        exp_cnt = 0;
        step();
        check("post_rst_enter", int'(thrust), 0);
        check("post_rst_diff", int'(difficulty), 3);
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_rst_hold", int'(thrust), 0);
        end
        joy_up = 1'b1;
        exp_thr = 0;
        for (int i = 0; i < 40 && exp_thr < 2; i++) begin
            step();
            if (was_tick) exp_thr++;
            check("post_rst_ramp", int'(thrust), exp_thr);
        end
        check("post_rst_dpad", int'(thrust), 2);
        joy_up = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
